// File: rtl/register_file_32.sv
// register_file_32
//   32 x DATA_WIDTH register file: two combinational read ports, one
//   synchronous write port. R0 is hardwired to zero.
//
//   Ports:
//     clk         rising-edge clock for register updates
//     reset       asynchronous, active-high; clears R1..R31
//     reg_write   write strobe
//     write_reg   5-bit write address (decoded to one-hot write_en)
//     write_data  data loaded into the addressed register
//     read_reg1/2 read addresses
//     read_data1/2 combinational read data
//     write_en    one-hot write-enable vector (bit 0 always 0)
//
//   Build option:
//     REGFILE_BYPASS_EN  when defined, a read of the address being written
//                        returns write_data in the same cycle (not during
//                        reset). When undefined, reads return stored data.

// One register slot: owns its own slice of the write decode so the
// decode and the enable it drives stay together.
module register_file_32_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int IDX        = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reg_write,
  input  logic [4:0]            write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic                  en,
  output logic [DATA_WIDTH-1:0] q
);
  localparam logic [4:0] ADDR = 5'(IDX);

  assign en = reg_write & (write_reg == ADDR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   q <= '0;
    else if (en) q <= write_data;
  end
endmodule

module register_file_32 #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reg_write,
  input  logic [4:0]            write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [4:0]            read_reg1,
  input  logic [4:0]            read_reg2,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2,
  output logic [31:0]           write_en
);
  logic [31:0][DATA_WIDTH-1:0] regs;

  // R0 has no storage and no enable: writes to address 0 vanish.
  assign regs[0]     = '0;
  assign write_en[0] = 1'b0;

  for (genvar k = 1; k < 32; k++) begin : g_reg
    register_file_32_reg #(
      .DATA_WIDTH (DATA_WIDTH),
      .IDX        (k)
    ) u_reg (
      .clk        (clk),
      .reset      (reset),
      .reg_write  (reg_write),
      .write_reg  (write_reg),
      .write_data (write_data),
      .en         (write_en[k]),
      .q          (regs[k])
    );
  end

  // Every 5-bit address maps to a real slot, so the read mux has no
  // undefined select values.
  logic [DATA_WIDTH-1:0] stored1, stored2;
  assign stored1 = regs[read_reg1];
  assign stored2 = regs[read_reg2];

`ifdef REGFILE_BYPASS_EN
  // write_en[0] is already masked, so a non-zero enable implies a live
  // write to a non-zero address.
  logic fwd_ok;
  assign fwd_ok = !reset && (write_en != '0);
  assign read_data1 = (fwd_ok && read_reg1 == write_reg) ? write_data : stored1;
  assign read_data2 = (fwd_ok && read_reg2 == write_reg) ? write_data : stored2;
`else
  assign read_data1 = stored1;
  assign read_data2 = stored2;
`endif
endmodule
